sram_arb_ctrl: RTL and testbench

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/sram_arb_ctrl_rr_arb2.sv | 18 +
 rtl/sram_arb_ctrl.sv | 103 ++++++++++
 tb/tb_sram_arb_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-requester SRAM arbitration controller.
package sram_ctrl_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time is granted; a lone requester is always granted.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Clears an external read-first SRAM after reset, then arbitrates two
// requesters onto it with one access per cycle and a one-cycle response.
module sram_arb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_din,
    input  logic [DATA_WIDTH-1:0]                mem_dout,
    output logic                                 init_done
);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    r_last_grant;
    logic [NUM_REQ-1:0]      r_rsp_pend;
    logic                    r_init_done;

    logic [NUM_REQ-1:0]      w_arb_grant;
    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_arb_active;
    logic                    w_sel;

    rr_arb2 u_rr_arb2 (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant)
    );

    // Grants are only honoured once clearing is over and reset is released.
    assign w_arb_active = (r_state == ST_ARB) && !rst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign w_grant[gi] = w_arb_active & w_arb_grant[gi];
        end
    endgenerate

    assign req_ready = w_grant;
    assign w_sel     = w_grant[1];

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                mem_we   = 1'b1;
                mem_addr = r_init_cnt;
            end else if (|w_grant) begin
                mem_we   = req_we[w_sel];
                mem_addr = req_addr[w_sel];
                mem_din  = req_wdata[w_sel];
            end
        end
    end

    // A response pending across a reset edge must never surface.
    assign rsp_valid = rst ? '0 : r_rsp_pend;
    assign rsp_rdata = (|rsp_valid) ? mem_dout : '0;
    assign init_done = r_init_done & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_last_grant <= 1'b1;   // "requester 1 won last" gives requester 0 priority
            r_rsp_pend   <= '0;
            r_init_done  <= 1'b0;
        end else begin
            r_rsp_pend <= w_grant;
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= ST_ARB;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (|w_grant) begin
                        r_last_grant <= w_grant[1];
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl paired with a behavioural read-first SRAM;
// expected responses are queued at handshake and checked by a separate monitor.
module tb_sram_arb_ctrl;
    import sram_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_we;
    logic [1:0][AW-1:0]      req_addr;
    logic [1:0][DW-1:0]      req_wdata;
    logic [1:0]              rsp_valid;
    logic [DW-1:0]           rsp_rdata;
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_din;
    logic [DW-1:0]           mem_dout;
    logic                    init_done;

    always #5 clk = ~clk;

    sram_arb_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .init_done (init_done)
    );

    // Read-first SRAM, seeded with non-zero contents so clearing is observable.
    logic [DW-1:0] sram [DEPTH] = '{default: 8'hEE};
    always @(posedge clk) begin
        mem_dout <= sram[mem_addr];
        if (mem_we) sram[mem_addr] <= mem_din;
    end

    typedef struct {
        int        id;
        logic [7:0] data;
        int        cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Expected write responses while both requesters contend (0,1,0,1,0,1).
    logic [7:0] rr_exp [6] = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h11, 8'h21};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        q.push_back('{id: id, data: d, cyc: cyc + 1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response is matched against the head of the queue.
    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h expected no response", rsp_valid, rsp_rdata);
            end else begin
                e = q.pop_front();
                if (rsp_valid !== (2'b01 << e.id) || rsp_rdata !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL rsp_check: got valid=%b data=%h cyc=%0d expected req=%0d data=%h cyc=%0d",
                             rsp_valid, rsp_rdata, cyc, e.id, e.data, e.cyc);
                end else begin
                    $display("rsp req=%0d data=%h cyc=%0d", e.id, rsp_rdata, cyc);
                end
            end
        end else begin
            total++;
            if (rsp_rdata !== '0) begin
                bad++;
                $display("FAIL idle_rdata: got %h expected 00", rsp_rdata);
            end
        end
    end

    // Issue one request, wait (bounded) for its grant and queue the expected response.
    task automatic do_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        logic got;
        got          = 1'b0;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        chk($sformatf("handshake_req%0d_addr%0d", i, a), 32'(got), 32'd1);
        if (got) push(i, exp_d);
        $display("req%0d %s addr=%0d wdata=%h expect=%h", i, we ? "wr" : "rd", a, d, exp_d);
        step();
        req_valid[i] = 1'b0;
    endtask

    // Sixteen clearing writes, with requests held off throughout.
    task automatic init_seq(input string tag, input logic [1:0] ready_exp);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, k),
                32'({mem_we, mem_addr, mem_din, init_done, req_ready}),
                32'({1'b1, k[AW-1:0], 8'h00, 1'b0, ready_exp}));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            32'({req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_din, init_done}), 32'd0);

        // Clearing after reset release, no requests.
        step();
        rst = 1'b0;
        init_seq("initA", 2'b00);
        @(negedge clk);
        chk("initA_done", 32'({init_done, mem_we}), 32'b10);
        step();

        do_req(0, 1'b0, 4'd0,  8'h00, 8'h00);
        do_req(0, 1'b0, 4'd15, 8'h00, 8'h00);

        // Write then immediate read: read-first write response, new data on read.
        do_req(0, 1'b1, 4'd3, 8'hAA, 8'h00);
        do_req(0, 1'b0, 4'd3, 8'h00, 8'hAA);
        do_req(1, 1'b1, 4'd3, 8'h55, 8'hAA);
        do_req(1, 1'b0, 4'd3, 8'h00, 8'h55);

        // Continuous contention; requester 1 won last so 0 leads.
        req_we       = 2'b11;
        req_addr[0]  = 4'd6;
        req_addr[1]  = 4'd7;
        req_wdata[0] = 8'h10;
        req_wdata[1] = 8'h20;
        req_valid    = 2'b11;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 2;
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(2'b01 << g));
            push(g, rr_exp[k]);
            $display("req%0d wr addr=%0d wdata=%h expect=%h", g, req_addr[g], req_wdata[g], rr_exp[k]);
            step();
            req_wdata[g] = req_wdata[g] + 8'h01;
        end
        req_valid = 2'b00;
        do_req(0, 1'b0, 4'd6, 8'h00, 8'h12);
        do_req(1, 1'b0, 4'd7, 8'h00, 8'h22);

        step();
        step();
        chk("queue_drained_1", 32'(q.size()), 32'd0);

        // Reset right after a read handshake: the response must be dropped.
        req_we[0]   = 1'b0;
        req_addr[0] = 4'd6;
        req_valid   = 2'b01;
        @(negedge clk);
        chk("abort_handshake", 32'(req_ready), 32'b01);
        $display("req0 rd addr=6 aborted by reset");
        step();
        req_valid = 2'b00;
        rst       = 1'b1;
        @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

        // Request raised during reset/clearing waits for the first arbitration cycle.
        step();
        req_we[1]   = 1'b0;
        req_addr[1] = 4'd6;
        req_valid   = 2'b10;
        step();
        rst = 1'b0;
        init_seq("initB", 2'b00);
        @(negedge clk);
        chk("initB_grant", 32'({init_done, req_ready}), 32'b110);
        push(1, 8'h00);
        $display("req1 rd addr=6 expect=00 (held through clearing)");
        step();
        req_valid = 2'b00;

        step();
        step();
        chk("queue_drained_2", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
